// File: rtl/raycast_pkg.sv
`default_nettype none
// ============================================================================
// Package : raycast_pkg
// Brief   : Shared constants, state encoding and coordinate type for the
//           raycaster wall-search stages.
// Rev     : 1.0 - initial release
// ============================================================================
package raycast_pkg;

  // Default map geometry: 16x16 tiles of 64 world units
  localparam int C_TILE_SHIFT = 6;
  localparam int C_MAP_W      = 16;
  localparam int C_MAP_H      = 16;
  localparam int C_COORD_W    = 13;

  // Wall-search state encoding
  localparam int C_STATE_W = 3;
  typedef logic [C_STATE_W-1:0] state_t;

  localparam state_t C_ST_IDLE  = 3'd0;
  localparam state_t C_ST_CHECK = 3'd1;
  localparam state_t C_ST_REQ   = 3'd2;
  localparam state_t C_ST_STEP  = 3'd3;
  localparam state_t C_ST_DONE  = 3'd4;

  // Signed ray coordinate: one extra bit so a ray can leave the map on
  // the negative side without aliasing back into it
  typedef logic signed [C_COORD_W:0] coord_s_t;

endpackage
`default_nettype wire

// File: rtl/grid_cell_addr.sv
`default_nettype none
// ============================================================================
// Module : grid_cell_addr
// Brief  : Combinational probe-point adjust, map bounds check and map cell
//          address for a ray point sitting on a grid line.
// Rev    : 1.0 - initial release
// ============================================================================
module grid_cell_addr
  import raycast_pkg::*;
#(
  parameter int COORD_W    = C_COORD_W,
  parameter int TILE_SHIFT = C_TILE_SHIFT,
  parameter int MAP_W      = C_MAP_W,
  parameter int MAP_H      = C_MAP_H,
  parameter int MAP_AW     = $clog2(MAP_W * MAP_H)
) (
  input  logic                      mode,
  input  logic signed [COORD_W:0]   cur_x,
  input  logic signed [COORD_W:0]   cur_y,
  input  logic                      step_x_neg,
  input  logic                      step_y_neg,
  output logic                      out_of_bounds,
  output logic [MAP_AW-1:0]         cell_addr
);

  // One bit wider than the ray so the -1 probe adjust can never wrap
  localparam int C_PW = COORD_W + 2;
  localparam logic signed [C_PW-1:0] C_LIM_X = C_PW'(MAP_W << TILE_SHIFT);
  localparam logic signed [C_PW-1:0] C_LIM_Y = C_PW'(MAP_H << TILE_SHIFT);

  logic signed [C_PW-1:0] w_px;
  logic signed [C_PW-1:0] w_py;
  logic [MAP_AW-1:0]      w_cell_x;
  logic [MAP_AW-1:0]      w_cell_y;

  // A ray moving in the negative direction sits on the boundary of the
  // cell it is about to enter, so the crossed axis is nudged back by one
  always_comb begin
    w_px = C_PW'(cur_x);
    w_py = C_PW'(cur_y);
    if (mode && step_x_neg) begin
      w_px = w_px - C_PW'(1);
    end
    if (!mode && step_y_neg) begin
      w_py = w_py - C_PW'(1);
    end

    out_of_bounds = w_px[C_PW-1] || (w_px >= C_LIM_X) ||
                    w_py[C_PW-1] || (w_py >= C_LIM_Y);

    w_cell_x  = MAP_AW'(w_px >>> TILE_SHIFT);
    w_cell_y  = MAP_AW'(w_py >>> TILE_SHIFT);
    cell_addr = MAP_AW'(w_cell_y * MAP_AW'(MAP_W)) + w_cell_x;
  end

endmodule
`default_nettype wire

// File: rtl/find_wall_intersection_grid.sv
`default_nettype none
// ============================================================================
// Module : find_wall_intersection_grid
// Brief  : Marches a ray along horizontal (mode=0) or vertical (mode=1)
//          grid-line intersections, reading the map over a req/ack
//          handshake until a wall, the map edge or the step limit.
// Rev    : 1.0 - initial release
// ============================================================================
module find_wall_intersection_grid
  import raycast_pkg::*;
#(
  parameter int COORD_W    = C_COORD_W,
  parameter int TILE_SHIFT = C_TILE_SHIFT,
  parameter int MAP_W      = C_MAP_W,
  parameter int MAP_H      = C_MAP_H,
  parameter int MAX_STEPS  = 32,
  parameter int MAP_AW     = $clog2(MAP_W * MAP_H)
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             begin_calc,
  input  logic                             mode,
  input  logic [COORD_W-1:0]               startX,
  input  logic [COORD_W-1:0]               startY,
  input  logic signed [COORD_W:0]          stepX,
  input  logic signed [COORD_W:0]          stepY,
  output logic                             map_req,
  output logic [MAP_AW-1:0]                map_addr,
  input  logic                             map_ack,
  input  logic                             map_data,
  output logic [COORD_W-1:0]               wallX,
  output logic [COORD_W-1:0]               wallY,
  output logic [$clog2(MAX_STEPS+1)-1:0]   step_count,
  output logic                             wall_found,
  output logic                             end_calc,
  output logic                             busy
);

  localparam int C_SC_W = $clog2(MAX_STEPS + 1);

  state_t                  r_state;
  state_t                  w_state_next;

  logic                    r_mode;
  logic signed [COORD_W:0] r_step_x;
  logic signed [COORD_W:0] r_step_y;
  logic signed [COORD_W:0] r_cur_x;
  logic signed [COORD_W:0] r_cur_y;
  logic [MAP_AW-1:0]       r_map_addr;
  logic [COORD_W-1:0]      r_wall_x;
  logic [COORD_W-1:0]      r_wall_y;
  logic [C_SC_W-1:0]       r_step_count;
  logic                    r_wall_found;

  logic                    w_start;
  logic                    w_oob;
  logic                    w_at_limit;
  logic [MAP_AW-1:0]       w_cell_addr;

  assign w_start    = begin_calc && ((r_state == C_ST_IDLE) || (r_state == C_ST_DONE));
  assign w_at_limit = (r_step_count >= C_SC_W'(MAX_STEPS));

  grid_cell_addr #(
    .COORD_W    (COORD_W),
    .TILE_SHIFT (TILE_SHIFT),
    .MAP_W      (MAP_W),
    .MAP_H      (MAP_H),
    .MAP_AW     (MAP_AW)
  ) u_cell (
    .mode          (r_mode),
    .cur_x         (r_cur_x),
    .cur_y         (r_cur_y),
    .step_x_neg    (r_step_x[COORD_W]),
    .step_y_neg    (r_step_y[COORD_W]),
    .out_of_bounds (w_oob),
    .cell_addr     (w_cell_addr)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_ST_IDLE:  if (begin_calc) w_state_next = C_ST_CHECK;
      C_ST_CHECK: w_state_next = w_oob ? C_ST_DONE : C_ST_REQ;
      C_ST_REQ: begin
        if (map_ack) begin
          if (map_data || w_at_limit) begin
            w_state_next = C_ST_DONE;
          end else begin
            w_state_next = C_ST_STEP;
          end
        end
      end
      C_ST_STEP:  w_state_next = C_ST_CHECK;
      C_ST_DONE:  if (begin_calc) w_state_next = C_ST_CHECK;
      default:    w_state_next = C_ST_IDLE;
    endcase
  end

  // State-decoded handshake and status outputs
  always_comb begin
    map_req  = (r_state == C_ST_REQ);
    busy     = (r_state == C_ST_CHECK) || (r_state == C_ST_REQ) || (r_state == C_ST_STEP);
    end_calc = (r_state == C_ST_DONE);
  end

  // Ray datapath: latch a new job, register the probe address, advance the
  // ray and capture the final point on the way into DONE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mode       <= 1'b0;
      r_step_x     <= '0;
      r_step_y     <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_map_addr   <= '0;
      r_wall_x     <= '0;
      r_wall_y     <= '0;
      r_step_count <= '0;
      r_wall_found <= 1'b0;
    end else if (w_start) begin
      r_mode       <= mode;
      r_step_x     <= stepX;
      r_step_y     <= stepY;
      r_cur_x      <= {1'b0, startX};
      r_cur_y      <= {1'b0, startY};
      r_wall_x     <= '0;
      r_wall_y     <= '0;
      r_step_count <= '0;
      r_wall_found <= 1'b0;
    end else begin
      if ((r_state == C_ST_CHECK) && !w_oob) begin
        r_map_addr <= w_cell_addr;
      end
      if ((r_state == C_ST_REQ) && map_ack && map_data) begin
        r_wall_found <= 1'b1;
      end
      if (r_state == C_ST_STEP) begin
        r_cur_x      <= r_cur_x + r_step_x;
        r_cur_y      <= r_cur_y + r_step_y;
        r_step_count <= r_step_count + C_SC_W'(1);
      end
      if ((r_state != C_ST_DONE) && (w_state_next == C_ST_DONE)) begin
        r_wall_x <= r_cur_x[COORD_W-1:0];
        r_wall_y <= r_cur_y[COORD_W-1:0];
      end
    end
  end

  assign map_addr   = r_map_addr;
  assign wallX      = r_wall_x;
  assign wallY      = r_wall_y;
  assign step_count = r_step_count;
  assign wall_found = r_wall_found;

endmodule
`default_nettype wire
